// File: rtl/gpio_debounce_chk.sv
// -----------------------------------------------------------------------------
// gpio_debounce_chk
// Property checker for the gpio_debounce event register. Holds no design
// state; it only observes the registered event outputs.
//
// Ports:
//   clk, rst     - same clock/reset as the checked block
//   ev_valid     - event pending flag
//   ev_rise      - pending rising-edge bits
//   ev_fall      - pending falling-edge bits
//   ev_overflow  - pending event contains merged changes
// -----------------------------------------------------------------------------
module gpio_debounce_chk #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    input logic             ev_valid,
    input logic [WIDTH-1:0] ev_rise,
    input logic [WIDTH-1:0] ev_fall,
    input logic             ev_overflow
);

    // With no event pending, the payload must be fully cleared.
    a_idle_payload_clear : assert property (
        @(posedge clk) disable iff (rst)
        !ev_valid |-> ((ev_rise == {WIDTH{1'b0}}) && (ev_fall == {WIDTH{1'b0}}) && !ev_overflow)
    );

    // A bit can only be both rising and falling after two accepts were merged.
    a_both_edges_needs_merge : assert property (
        @(posedge clk) disable iff (rst)
        ((ev_rise & ev_fall) != {WIDTH{1'b0}}) |-> ev_overflow
    );

endmodule

// File: rtl/gpio_sync2.sv
// -----------------------------------------------------------------------------
// gpio_sync2
// WIDTH-wide two-flop synchronizer for asynchronous pad inputs. Each bit is
// synchronized independently; bits are not guaranteed coherent with each other
// on the same cycle, which is fine for debounced switch inputs.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset (clears both flop stages)
//   d    - raw asynchronous inputs
//   q    - synchronized outputs (second flop stage)
// -----------------------------------------------------------------------------
module gpio_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;

    // Two back-to-back flops resolve metastability on the raw pad inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// Samples up to 32 asynchronous switch/button pads, debounces them with one
// shared stability counter, presents a registered debounced state bus and
// emits one change event per accepted transition over a valid/ready handshake.
//
// Ports:
//   clk          - system clock, all logic on rising edge
//   rst          - synchronous, active-high reset
//   pins         - raw asynchronous pad inputs [WIDTH]
//   state        - debounced pin state [WIDTH]
//   ev_valid     - change event pending
//   ev_ready     - consumer accepts the event when high together with ev_valid
//   ev_rise      - bits that went 0->1 since the last accepted event [WIDTH]
//   ev_fall      - bits that went 1->0 since the last accepted event [WIDTH]
//   ev_overflow  - a further change was merged into a pending event
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module gpio_debounce #(
    parameter int WIDTH    = 16,
    parameter int DEBOUNCE = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_rise,
    output logic [WIDTH-1:0] ev_fall,
    output logic             ev_overflow
);

    localparam int             CNT_W   = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] last_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_s;
    logic             at_max_s;

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] state_nxt_s;
    logic             accept_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;

    logic             handshake_s;
    logic             ev_valid_r;
    logic [WIDTH-1:0] ev_rise_r;
    logic [WIDTH-1:0] ev_fall_r;
    logic             ev_overflow_r;
    logic             ev_valid_nxt_s;
    logic [WIDTH-1:0] ev_rise_nxt_s;
    logic [WIDTH-1:0] ev_fall_nxt_s;
    logic             ev_overflow_nxt_s;

    gpio_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pins),
        .q   (sync_s)
    );

    // Previous synchronized sample, used to detect any change on any bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= {WIDTH{1'b0}};
        end else begin
            last_r <= sync_s;
        end
    end

    // Shared stability counter: any bit moving restarts the count; it
    // saturates at DEBOUNCE-1 so a long-stable input never re-triggers.
    always_comb begin
        stable_s  = (sync_s == last_r);
        at_max_s  = (cnt_r == CNT_MAX);
        cnt_nxt_s = cnt_r;
        if (!stable_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (!at_max_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Stability counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // A change is accepted once the synchronized value has been stable long
    // enough and differs from the published state.
    always_comb begin
        accept_s    = at_max_s && (last_r != state_r);
        rise_s      = last_r & ~state_r;
        fall_s      = ~last_r & state_r;
        state_nxt_s = state_r;
        if (accept_s) begin
            state_nxt_s = last_r;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Debounced state register; never waits on the event consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Event register next-state: replace when the slot is free or being
    // consumed this cycle, otherwise merge into the pending event and flag it.
    always_comb begin
        handshake_s       = ev_valid_r & ev_ready;
        ev_valid_nxt_s    = ev_valid_r;
        ev_rise_nxt_s     = ev_rise_r;
        ev_fall_nxt_s     = ev_fall_r;
        ev_overflow_nxt_s = ev_overflow_r;
        if (accept_s) begin
            ev_valid_nxt_s = 1'b1;
            if (ev_valid_r && !handshake_s) begin
                ev_rise_nxt_s     = ev_rise_r | rise_s;
                ev_fall_nxt_s     = ev_fall_r | fall_s;
                ev_overflow_nxt_s = 1'b1;
            end else begin
                ev_rise_nxt_s     = rise_s;
                ev_fall_nxt_s     = fall_s;
                ev_overflow_nxt_s = 1'b0;
            end
        end else begin
            if (handshake_s) begin
                ev_valid_nxt_s    = 1'b0;
                ev_rise_nxt_s     = {WIDTH{1'b0}};
                ev_fall_nxt_s     = {WIDTH{1'b0}};
                ev_overflow_nxt_s = 1'b0;
            end else begin
                ev_valid_nxt_s    = ev_valid_r;
                ev_rise_nxt_s     = ev_rise_r;
                ev_fall_nxt_s     = ev_fall_r;
                ev_overflow_nxt_s = ev_overflow_r;
            end
        end
    end

    // Event register; reset discards any pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_r    <= 1'b0;
            ev_rise_r     <= {WIDTH{1'b0}};
            ev_fall_r     <= {WIDTH{1'b0}};
            ev_overflow_r <= 1'b0;
        end else begin
            ev_valid_r    <= ev_valid_nxt_s;
            ev_rise_r     <= ev_rise_nxt_s;
            ev_fall_r     <= ev_fall_nxt_s;
            ev_overflow_r <= ev_overflow_nxt_s;
        end
    end

    assign state       = state_r;
    assign ev_valid    = ev_valid_r;
    assign ev_rise     = ev_rise_r;
    assign ev_fall     = ev_fall_r;
    assign ev_overflow = ev_overflow_r;

    gpio_debounce_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .ev_valid    (ev_valid_r),
        .ev_rise     (ev_rise_r),
        .ev_fall     (ev_fall_r),
        .ev_overflow (ev_overflow_r)
    );

endmodule
